// File: rtl/semi_auto_nav.sv
// Semi-automatic driving controller: debounces the three obstacle detectors and
// steers forward / turns / waits for a user command at multi-way junctions.
module semi_auto_nav #(
    parameter int unsigned DEB_CYCLES   = 1_000_000,
    parameter int unsigned TURN_CYCLES  = 90_000_000,
    parameter int unsigned LEAVE_CYCLES = 50_000_000,
    parameter int unsigned CNT_W        = 28
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       front_detector,
    input  logic       left_detector,
    input  logic       right_detector,
    input  logic       cmd_fwd,
    input  logic       cmd_left,
    input  logic       cmd_right,
    input  logic       cmd_back,
    output logic [3:0] moving_state,
    output logic [2:0] nav_state,
    output logic       wait_cmd
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] BACK_LAST  = CNT_W'(2 * TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LEAVE_LAST = CNT_W'(LEAVE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECIDE    = 3'd1,
        FORWARD   = 3'd2,
        LEAVE     = 3'd3,
        TURN_L    = 3'd4,
        TURN_R    = 3'd5,
        TURN_BACK = 3'd6,
        WAIT_CMD  = 3'd7
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] timer;

    // Detector index: 0 front, 1 left, 2 right; filtered value 1 = blocked.
    logic             raw  [3];
    logic             filt [3];
    logic [CNT_W-1:0] dcnt [3];

    assign raw[0] = front_detector;
    assign raw[1] = left_detector;
    assign raw[2] = right_detector;

    // A raw value must disagree for DEB_CYCLES consecutive edges to be accepted.
    for (genvar i = 0; i < 3; i++) begin : g_deb
        always_ff @(posedge sys_clk or negedge rst) begin
            if (!rst) begin
                filt[i] <= 1'b1;
                dcnt[i] <= '0;
            end else if (raw[i] == filt[i]) begin
                dcnt[i] <= '0;
            end else if (dcnt[i] == DEB_LAST) begin
                filt[i] <= raw[i];
                dcnt[i] <= '0;
            end else begin
                dcnt[i] <= dcnt[i] + CNT_W'(1);
            end
        end
    end

    logic       f_open;
    logic       l_open;
    logic       r_open;
    logic [1:0] n_open;

    assign f_open = ~filt[0];
    assign l_open = ~filt[1];
    assign r_open = ~filt[2];
    assign n_open = 2'(f_open) + 2'(l_open) + 2'(r_open);

    function automatic logic [3:0] mov_of(input state_t s);
        case (s)
            FORWARD, LEAVE:    mov_of = 4'b0001;
            TURN_L, TURN_BACK: mov_of = 4'b0100;
            TURN_R:            mov_of = 4'b1000;
            default:           mov_of = 4'b0000;
        endcase
    endfunction

    // Next-state decision; turns ignore the detectors until their timer expires.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:   nxt = DECIDE;
            DECIDE: begin
                if (n_open == 2'd0)      nxt = TURN_BACK;
                else if (n_open == 2'd1) nxt = f_open ? LEAVE : (l_open ? TURN_L : TURN_R);
                else                     nxt = WAIT_CMD;
            end
            FORWARD: if (!f_open || l_open || r_open) nxt = DECIDE;
            LEAVE: begin
                if (!f_open)                 nxt = DECIDE;
                else if (timer == LEAVE_LAST) nxt = FORWARD;
            end
            TURN_L, TURN_R: if (timer == TURN_LAST) nxt = LEAVE;
            TURN_BACK:      if (timer == BACK_LAST) nxt = LEAVE;
            WAIT_CMD: begin
                if (cmd_fwd && f_open)        nxt = LEAVE;
                else if (cmd_left && l_open)  nxt = TURN_L;
                else if (cmd_right && r_open) nxt = TURN_R;
                else if (cmd_back)            nxt = TURN_BACK;
            end
            default: nxt = IDLE;
        endcase
        if (!enable) nxt = IDLE;
    end

    // State, timer and all outputs update together so moving_state tracks the transition edge.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            timer        <= '0;
            moving_state <= 4'b0000;
            wait_cmd     <= 1'b0;
        end else if (nxt != state || !enable) begin
            state        <= nxt;
            timer        <= '0;
            moving_state <= mov_of(nxt);
            wait_cmd     <= (nxt == WAIT_CMD);
        end else if (state == LEAVE || state == TURN_L || state == TURN_R || state == TURN_BACK) begin
            timer <= timer + CNT_W'(1);
        end
    end

    assign nav_state = state;

endmodule

// File: tb/tb_semi_auto_nav.sv
// Scoreboard bench for semi_auto_nav: a behavioural model predicts the outputs
// after every clock edge, and a monitor compares them against the DUT.
module tb_semi_auto_nav;

    localparam int DEB_C   = 3;
    localparam int TURN_C  = 8;
    localparam int LEAVE_C = 5;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       front_detector = 1'b0;
    logic       left_detector = 1'b0;
    logic       right_detector = 1'b0;
    logic       cmd_fwd = 1'b0;
    logic       cmd_left = 1'b0;
    logic       cmd_right = 1'b0;
    logic       cmd_back = 1'b0;
    logic [3:0] moving_state;
    logic [2:0] nav_state;
    logic       wait_cmd;

    semi_auto_nav #(
        .DEB_CYCLES  (DEB_C),
        .TURN_CYCLES (TURN_C),
        .LEAVE_CYCLES(LEAVE_C),
        .CNT_W       (28)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .enable        (enable),
        .front_detector(front_detector),
        .left_detector (left_detector),
        .right_detector(right_detector),
        .cmd_fwd       (cmd_fwd),
        .cmd_left      (cmd_left),
        .cmd_right     (cmd_right),
        .cmd_back      (cmd_back),
        .moving_state  (moving_state),
        .nav_state     (nav_state),
        .wait_cmd      (wait_cmd)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // Values applied at the next falling edge
    logic n_rst = 1'b0, n_en = 1'b0;
    logic n_f = 1'b0, n_l = 1'b0, n_r = 1'b0;
    logic n_cf = 1'b0, n_cl = 1'b0, n_cr = 1'b0, n_cb = 1'b0;

    // Reference model: state codes 0 idle,1 decide,2 forward,3 leave,4 left,5 right,6 back,7 wait
    int       m_st;
    int       m_t;
    bit       m_blk[3];
    int       m_run[3];
    bit [3:0] m_mov;
    bit       m_wt;

    function automatic int dur(input int s);
        if (s == 3) return LEAVE_C;
        if (s == 4 || s == 5) return TURN_C;
        if (s == 6) return 2 * TURN_C;
        return 0;
    endfunction

    function automatic bit [3:0] mov_for(input int s);
        if (s == 2 || s == 3) return 4'b0001;
        if (s == 4 || s == 6) return 4'b0100;
        if (s == 5) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic int pick_way(input bit fo, input bit lo, input bit ro);
        int n;
        n = int'(fo) + int'(lo) + int'(ro);
        if (n == 0) return 6;
        if (n >= 2) return 7;
        if (fo) return 3;
        return lo ? 4 : 5;
    endfunction

    function automatic void model_reset();
        m_st = 0;
        m_t = 0;
        m_mov = 4'b0000;
        m_wt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_blk[i] = 1'b1;
            m_run[i] = 0;
        end
    endfunction

    function automatic void model_step();
        bit fo, lo, ro;
        bit rw[3];
        int tgt;
        fo = !m_blk[0];
        lo = !m_blk[1];
        ro = !m_blk[2];
        tgt = m_st;
        if (!n_en) tgt = 0;
        else begin
            case (m_st)
                0: tgt = 1;
                1: tgt = pick_way(fo, lo, ro);
                2: if (!fo || lo || ro) tgt = 1;
                3: begin
                    if (!fo) tgt = 1;
                    else if (m_t + 1 == dur(3)) tgt = 2;
                end
                4, 5, 6: if (m_t + 1 == dur(m_st)) tgt = 3;
                default: begin
                    if (n_cf && fo) tgt = 3;
                    else if (n_cl && lo) tgt = 4;
                    else if (n_cr && ro) tgt = 5;
                    else if (n_cb) tgt = 6;
                end
            endcase
        end
        if (!n_en || tgt != m_st) begin
            m_st = tgt;
            m_t = 0;
            m_mov = mov_for(tgt);
            m_wt = (tgt == 7);
        end else if (dur(m_st) > 0) begin
            m_t++;
        end
        // Filters: a value must differ for DEB_C consecutive cycles
        rw[0] = n_f;
        rw[1] = n_l;
        rw[2] = n_r;
        for (int i = 0; i < 3; i++) begin
            if (rw[i] == m_blk[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DEB_C) begin
                    m_blk[i] = rw[i];
                    m_run[i] = 0;
                end
            end
        end
    endfunction

    task automatic tick();
        @(negedge sys_clk);
        rst = n_rst;
        enable = n_en;
        front_detector = n_f;
        left_detector = n_l;
        right_detector = n_r;
        cmd_fwd = n_cf;
        cmd_left = n_cl;
        cmd_right = n_cr;
        cmd_back = n_cb;
        if (!n_rst) model_reset();
        else model_step();
        exp_q.push_back({3'(m_st), m_mov, m_wt});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_raw(input logic f, input logic l, input logic r);
        n_f = f;
        n_l = l;
        n_r = r;
    endtask

    task automatic check_now(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Monitor: one expected response per clock edge
    initial begin
        logic [7:0] e, a;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {nav_state, moving_state, wait_cmd};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL edge_outputs at %0t: got nav=%0d mov=%b wait=%b expected nav=%0d mov=%b wait=%b",
                             $time, a[7:5], a[4:1], a[0], e[7:5], e[4:1], e[0]);
                end
            end
        end
    end

    initial begin
        model_reset();
        // All open after reset -> multi-way junction -> wait for command
        set_raw(0, 0, 0);
        run(2);
        n_rst = 1;
        run(4);
        n_en = 1;
        run(3);
        #1;
        check_now("wait_state", int'(nav_state), 7);
        check_now("wait_flag", int'(wait_cmd), 1);
        check_now("wait_mov", int'(moving_state), 0);

        // Only left open -> 90-degree left turn, leave, forward
        n_en = 0;
        set_raw(1, 0, 1);
        run(5);
        n_en = 1;
        run(2);
        set_raw(0, 1, 1);
        run(17);
        #1;
        check_now("forward_state", int'(nav_state), 2);
        check_now("forward_mov", int'(moving_state), 1);

        // Short left glitch is filtered; a held opening triggers a decision
        n_l = 0;
        run(2);
        n_l = 1;
        run(4);
        #1;
        check_now("glitch_ignored", int'(nav_state), 2);
        n_l = 0;
        run(6);
        #1;
        check_now("junction_wait", int'(nav_state), 7);

        // Command naming a blocked way is ignored; fwd beats right
        set_raw(0, 1, 0);
        run(4);
        n_cl = 1;
        run(1);
        n_cl = 0;
        run(2);
        #1;
        check_now("blocked_cmd", int'(nav_state), 7);
        n_cf = 1;
        n_cr = 1;
        run(1);
        n_cf = 0;
        n_cr = 0;
        run(1);
        #1;
        check_now("fwd_priority", int'(nav_state), 3);

        // Dead end -> U-turn
        n_en = 0;
        set_raw(1, 1, 1);
        run(4);
        n_en = 1;
        run(25);

        // Asynchronous reset mid right turn
        n_en = 0;
        set_raw(1, 1, 0);
        run(4);
        n_en = 1;
        run(6);
        #1;
        check_now("in_turn_r", int'(nav_state), 5);
        n_rst = 0;
        run(1);
        #1;
        check_now("async_rst_nav", int'(nav_state), 0);
        check_now("async_rst_mov", int'(moving_state), 0);
        n_rst = 1;
        run(6);
        n_en = 0;
        run(1);
        run(1);
        #1;
        check_now("en_drop_nav", int'(nav_state), 0);
        check_now("en_drop_mov", int'(moving_state), 0);
        n_en = 1;

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) n_f = ~n_f;
            if ($urandom_range(0, 11) == 0) n_l = ~n_l;
            if ($urandom_range(0, 11) == 0) n_r = ~n_r;
            n_cf = ($urandom_range(0, 5) == 0);
            n_cl = ($urandom_range(0, 5) == 0);
            n_cr = ($urandom_range(0, 5) == 0);
            n_cb = ($urandom_range(0, 5) == 0);
            n_en = ($urandom_range(0, 199) != 0);
            n_rst = ($urandom_range(0, 499) != 0);
            tick();
        end
        n_cf = 0;
        n_cl = 0;
        n_cr = 0;
        n_cb = 0;
        @(posedge sys_clk);
        #2;
        check_now("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
